// File: rtl/conv3x3_mc_engine.sv
// rtl/conv3x3_mc_engine.sv - multi-channel 3x3 valid convolution engine, double-buffered weights
// Optional macro CONV_RELU_EN: clamp negative saturated results to zero.
module conv3x3_mc_engine #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int C_IN       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WGT_WIDTH  = 8,
    parameter int BIAS_WIDTH = 16,
    parameter int OUT_WIDTH  = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [C_IN*DATA_WIDTH-1:0]     din,
    input  logic                           din_valid,
    output logic                           din_ready,
    output logic [OUT_WIDTH-1:0]           dout,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic                           frame_done,
    input  logic                           cfg_we,
    input  logic [$clog2(9*C_IN)-1:0]      cfg_addr,
    input  logic [WGT_WIDTH-1:0]           cfg_data,
    input  logic                           bias_we,
    input  logic [BIAS_WIDTH-1:0]          bias_data,
    input  logic                           cfg_commit,
    output logic                           cfg_pending
);
    localparam int NW    = 9 * C_IN;
    localparam int PIX_W = C_IN * DATA_WIDTH;
    localparam int PW    = DATA_WIDTH + 1 + WGT_WIDTH;
    localparam int ACC_W = DATA_WIDTH + WGT_WIDTH + 1 + $clog2(NW);
    localparam int MAX_W = (ACC_W > BIAS_WIDTH) ? ACC_W : BIAS_WIDTH;
    localparam int SUM_W = ((MAX_W > OUT_WIDTH) ? MAX_W : OUT_WIDTH) + 1;
    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI - SUM_W'(1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic signed [WGT_WIDTH-1:0]  w_shadow [NW];
    logic signed [WGT_WIDTH-1:0]  w_active [NW];
    logic signed [BIAS_WIDTH-1:0] b_shadow, b_active;

    logic [PIX_W-1:0] lb0 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] win [3][2];
    logic [PIX_W-1:0] newcol [3];
    logic [PIX_W-1:0] taps [3][3];

    logic signed [PW-1:0]    prod_c [NW];
    logic signed [PW-1:0]    s1_prod [NW];
    logic signed [ACC_W-1:0] sum_c, s2_sum;
    logic signed [SUM_W-1:0] full;
    logic [OUT_WIDTH-1:0]    res;
    logic s1_valid, s1_last, s2_valid, s2_last, dout_last;
    logic stall, apply, accept, win_ok, pix_last;

    assign stall     = dout_valid & ~dout_ready;
    assign apply     = cfg_pending & (row == '0) & (col == '0) & ~s1_valid & ~s2_valid & ~dout_valid;
    assign din_ready = ~stall & ~apply;
    assign accept    = din_valid & din_ready;
    assign win_ok    = (row >= RW'(2)) & (col >= CW'(2));
    assign pix_last  = (row == ROW_LAST) & (col == COL_LAST);

    // Column entering the window: two buffered rows above plus the incoming pixel.
    always_comb begin
        newcol[0] = lb0[col];
        newcol[1] = lb1[col];
        newcol[2] = din;
        for (int ky = 0; ky < 3; ky++) begin
            taps[ky][0] = win[ky][0];
            taps[ky][1] = win[ky][1];
            taps[ky][2] = newcol[ky];
        end
    end

    always_comb begin
        for (int c = 0; c < C_IN; c++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    prod_c[c*9 + ky*3 + kx] =
                        PW'($signed({1'b0, taps[ky][kx][c*DATA_WIDTH +: DATA_WIDTH]}))
                        * PW'(w_active[c*9 + ky*3 + kx]);
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NW; i++)
            sum_c = sum_c + ACC_W'(s1_prod[i]);
    end

    always_comb begin
        full = SUM_W'(s2_sum) + SUM_W'(b_active);
        if (full > SAT_HI)
            res = SAT_HI[OUT_WIDTH-1:0];
        else if (full < SAT_LO)
            res = SAT_LO[OUT_WIDTH-1:0];
        else
            res = full[OUT_WIDTH-1:0];
`ifdef CONV_RELU_EN
        if (res[OUT_WIDTH-1])
            res = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= lb1[col];
            lb1[col] <= din;
            for (int ky = 0; ky < 3; ky++) begin
                win[ky][0] <= win[ky][1];
                win[ky][1] <= newcol[ky];
            end
        end
    end

    // Apply copies the shadow bank as it stood before any same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                w_shadow[i] <= '0;
                w_active[i] <= '0;
            end
            b_shadow <= '0;
            b_active <= '0;
        end else begin
            if (cfg_we && (int'(cfg_addr) < NW))
                w_shadow[cfg_addr] <= cfg_data;
            if (bias_we)
                b_shadow <= bias_data;
            if (apply) begin
                w_active <= w_shadow;
                b_active <= b_shadow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            cfg_pending <= 1'b0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s2_valid    <= 1'b0;
            s2_last     <= 1'b0;
            s2_sum      <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
            frame_done  <= 1'b0;
            for (int i = 0; i < NW; i++)
                s1_prod[i] <= '0;
        end else begin
            frame_done <= dout_valid & dout_ready & dout_last;
            if (apply)
                cfg_pending <= 1'b0;
            else if (cfg_commit)
                cfg_pending <= 1'b1;
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (!stall) begin
                s1_valid   <= accept & win_ok;
                s1_last    <= accept & pix_last;
                s1_prod    <= prod_c;
                s2_valid   <= s1_valid;
                s2_last    <= s1_last;
                s2_sum     <= sum_c;
                dout_valid <= s2_valid;
                dout_last  <= s2_last;
                if (s2_valid)
                    dout <= res;
            end
        end
    end
endmodule
